// File: rtl/video_timing_pkg.sv
// Shared constants for the 2-D raster timing generator.
// Contents:
//   VtgW          default width of every count and timing value
//   Vga*          640x480@60 reference timing (800x525 totals)
package video_timing_pkg;

  localparam int unsigned VtgW = 12;

  // Horizontal reference timing, in pixels.
  localparam int unsigned VgaHActive = 640;
  localparam int unsigned VgaHSyncS  = 656;
  localparam int unsigned VgaHSyncE  = 752;
  localparam int unsigned VgaHTotal  = 800;

  // Vertical reference timing, in lines.
  localparam int unsigned VgaVActive = 480;
  localparam int unsigned VgaVSyncS  = 490;
  localparam int unsigned VgaVSyncE  = 492;
  localparam int unsigned VgaVTotal  = 525;

  typedef logic [VtgW-1:0] vtg_count_t;

endpackage

// File: rtl/timing_axis.sv
// One axis (horizontal or vertical) of the raster timing generator.
// Ports:
//   clk, rst       clock, asynchronous active-low reset
//   step           advance the counter on this edge
//   active         visible positions on this axis
//   sync_s/sync_e  sync window [sync_s, sync_e); sync_e clamped to total
//   total          positions per period; total < 2 parks the counter at 0
//   pol            sync polarity, 1 = active-high
//   count          current position
//   wrap           combinational: the counter returns to 0 on this edge
//   blank          registered, describes the current count
//   sync           registered window decode, polarity applied
module timing_axis
  import video_timing_pkg::*;
#(
  parameter int unsigned W = VtgW
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         step,
  input  logic [W-1:0] active,
  input  logic [W-1:0] sync_s,
  input  logic [W-1:0] sync_e,
  input  logic [W-1:0] total,
  input  logic         pol,
  output logic [W-1:0] count,
  output logic         wrap,
  output logic         blank,
  output logic         sync
);

  localparam logic [W-1:0] One = W'(1);
  localparam logic [W-1:0] Two = W'(2);

  logic [W-1:0] count_q, count_d;
  logic [W-1:0] sync_end;
  logic         short_total;
  logic         blank_q, blank_d;
  logic         sync_act_q, sync_act_d;

  always_comb begin
    short_total = total < Two;
    // >= rather than == so a count stranded above a shrunken total still wraps.
    wrap        = step & ~short_total & (count_q >= total - One);

    count_d = count_q;
    if (short_total) begin
      count_d = '0;
    end else if (wrap) begin
      count_d = '0;
    end else if (step) begin
      count_d = count_q + One;
    end

    // Flags decode the next count so they line up with it once registered.
    sync_end   = (sync_e > total) ? total : sync_e;
    blank_d    = short_total | (count_d >= active);
    sync_act_d = (count_d >= sync_s) & (count_d < sync_end);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q    <= '0;
      blank_q    <= 1'b1;
      sync_act_q <= 1'b0;
    end else begin
      count_q    <= count_d;
      blank_q    <= blank_d;
      sync_act_q <= sync_act_d;
    end
  end

  assign count = count_q;
  assign blank = blank_q;
  assign sync  = sync_act_q ~^ pol;

endmodule

// File: rtl/video_timing_gen.sv
// 2-D raster timing generator: horizontal and vertical counters with programmable
// active/sync/total, per-axis sync polarity and a pixel clock-enable.
// Ports:
//   clk, rst                 clock, asynchronous active-low reset
//   en                       pixel enable; state only advances on en edges
//   h_active..h_total        horizontal timing, in pixels
//   v_active..v_total        vertical timing, in lines
//   hsync_pol, vsync_pol     sync polarity, 1 = active-high
//   hcount, vcount           current position
//   hblank, vblank, de       blanking and data-enable
//   hsync, vsync             sync outputs, polarity applied
//   line_start, frame_start  1-cycle strobes on the first cycle of a line / frame
// Build option:
//   VTG_SHADOW_EN  timing inputs and polarities are captured on the reset-exit prime
//                  cycle and on every frame_start edge; mid-frame changes wait for
//                  the next frame. Undefined: inputs are used live.
module video_timing_gen
  import video_timing_pkg::*;
#(
  parameter int unsigned W = VtgW
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [W-1:0] h_active,
  input  logic [W-1:0] h_sync_s,
  input  logic [W-1:0] h_sync_e,
  input  logic [W-1:0] h_total,
  input  logic [W-1:0] v_active,
  input  logic [W-1:0] v_sync_s,
  input  logic [W-1:0] v_sync_e,
  input  logic [W-1:0] v_total,
  input  logic         hsync_pol,
  input  logic         vsync_pol,
  output logic [W-1:0] hcount,
  output logic [W-1:0] vcount,
  output logic         hblank,
  output logic         vblank,
  output logic         hsync,
  output logic         vsync,
  output logic         de,
  output logic         line_start,
  output logic         frame_start
);

  logic         primed_q, primed_d;
  logic         line_start_q, line_start_d;
  logic         frame_start_q, frame_start_d;
  logic         h_step, h_wrap, v_wrap;
  logic         h_blank_r, v_blank_r, h_sync_r, v_sync_r;

  // Timing actually fed to the axes.
  logic [W-1:0] c_h_active, c_h_sync_s, c_h_sync_e, c_h_total;
  logic [W-1:0] c_v_active, c_v_sync_s, c_v_sync_e, c_v_total;
  logic         c_hpol, c_vpol;

`ifdef VTG_SHADOW_EN
  logic [W-1:0] sh_h_active, sh_h_sync_s, sh_h_sync_e, sh_h_total;
  logic [W-1:0] sh_v_active, sh_v_sync_s, sh_v_sync_e, sh_v_total;
  logic         sh_hpol, sh_vpol;
  logic         capture;

  assign capture = en & (~primed_q | (h_wrap & v_wrap));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sh_h_active <= '0;
      sh_h_sync_s <= '0;
      sh_h_sync_e <= '0;
      sh_h_total  <= '0;
      sh_v_active <= '0;
      sh_v_sync_s <= '0;
      sh_v_sync_e <= '0;
      sh_v_total  <= '0;
      sh_hpol     <= 1'b0;
      sh_vpol     <= 1'b0;
    end else if (capture) begin
      sh_h_active <= h_active;
      sh_h_sync_s <= h_sync_s;
      sh_h_sync_e <= h_sync_e;
      sh_h_total  <= h_total;
      sh_v_active <= v_active;
      sh_v_sync_s <= v_sync_s;
      sh_v_sync_e <= v_sync_e;
      sh_v_total  <= v_total;
      sh_hpol     <= hsync_pol;
      sh_vpol     <= vsync_pol;
    end
  end

  // Until primed the shadows hold nothing useful, so the live inputs drive the
  // reset-state sync levels and the prime-cycle decode. The first cycle of each
  // later frame is decoded with the outgoing frame's timing.
  always_comb begin
    if (primed_q) begin
      c_h_active = sh_h_active;
      c_h_sync_s = sh_h_sync_s;
      c_h_sync_e = sh_h_sync_e;
      c_h_total  = sh_h_total;
      c_v_active = sh_v_active;
      c_v_sync_s = sh_v_sync_s;
      c_v_sync_e = sh_v_sync_e;
      c_v_total  = sh_v_total;
      c_hpol     = sh_hpol;
      c_vpol     = sh_vpol;
    end else begin
      c_h_active = h_active;
      c_h_sync_s = h_sync_s;
      c_h_sync_e = h_sync_e;
      c_h_total  = h_total;
      c_v_active = v_active;
      c_v_sync_s = v_sync_s;
      c_v_sync_e = v_sync_e;
      c_v_total  = v_total;
      c_hpol     = hsync_pol;
      c_vpol     = vsync_pol;
    end
  end
`else
  always_comb begin
    c_h_active = h_active;
    c_h_sync_s = h_sync_s;
    c_h_sync_e = h_sync_e;
    c_h_total  = h_total;
    c_v_active = v_active;
    c_v_sync_s = v_sync_s;
    c_v_sync_e = v_sync_e;
    c_v_total  = v_total;
    c_hpol     = hsync_pol;
    c_vpol     = vsync_pol;
  end
`endif

  // The first en edge after reset only primes; counting starts on the next one.
  assign h_step   = en & primed_q;
  assign primed_d = primed_q | en;

  timing_axis #(
    .W (W)
  ) u_h_axis (
    .clk    (clk),
    .rst    (rst),
    .step   (h_step),
    .active (c_h_active),
    .sync_s (c_h_sync_s),
    .sync_e (c_h_sync_e),
    .total  (c_h_total),
    .pol    (c_hpol),
    .count  (hcount),
    .wrap   (h_wrap),
    .blank  (h_blank_r),
    .sync   (h_sync_r)
  );

  // h_wrap already includes en & primed, so it is the vertical step directly.
  timing_axis #(
    .W (W)
  ) u_v_axis (
    .clk    (clk),
    .rst    (rst),
    .step   (h_wrap),
    .active (c_v_active),
    .sync_s (c_v_sync_s),
    .sync_e (c_v_sync_e),
    .total  (c_v_total),
    .pol    (c_vpol),
    .count  (vcount),
    .wrap   (v_wrap),
    .blank  (v_blank_r),
    .sync   (v_sync_r)
  );

  always_comb begin
    line_start_d  = en & (~primed_q | h_wrap);
    frame_start_d = en & (~primed_q | (h_wrap & v_wrap));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      primed_q      <= 1'b0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      primed_q      <= primed_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
    end
  end

  // The axes decode continuously; until primed the outputs are held at their
  // reset values so an idle reset-exit shows blank and inactive sync.
  always_comb begin
    hblank      = h_blank_r | ~primed_q;
    vblank      = v_blank_r | ~primed_q;
    hsync       = primed_q ? h_sync_r : ~c_hpol;
    vsync       = primed_q ? v_sync_r : ~c_vpol;
    de          = ~hblank & ~vblank;
    line_start  = line_start_q;
    frame_start = frame_start_q;
  end

endmodule

// File: tb/tb_video_timing_gen.sv
// Directed self-checking bench for video_timing_gen.
// Test timing: h 4/5/6/8, v 3/4/5/6, both polarities active-high unless changed.
module tb_video_timing_gen;

  localparam int W = 12;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         en = 1'b0;
  logic [W-1:0] h_active, h_sync_s, h_sync_e, h_total;
  logic [W-1:0] v_active, v_sync_s, v_sync_e, v_total;
  logic         hsync_pol, vsync_pol;
  logic [W-1:0] hcount, vcount;
  logic         hblank, vblank, hsync, vsync, de, line_start, frame_start;

  int total = 0;
  int bad = 0;

  video_timing_gen #(
    .W (W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .h_active    (h_active),
    .h_sync_s    (h_sync_s),
    .h_sync_e    (h_sync_e),
    .h_total     (h_total),
    .v_active    (v_active),
    .v_sync_s    (v_sync_s),
    .v_sync_e    (v_sync_e),
    .v_total     (v_total),
    .hsync_pol   (hsync_pol),
    .vsync_pol   (vsync_pol),
    .hcount      (hcount),
    .vcount      (vcount),
    .hblank      (hblank),
    .vblank      (vblank),
    .hsync       (hsync),
    .vsync       (vsync),
    .de          (de),
    .line_start  (line_start),
    .frame_start (frame_start)
  );

  always #5 clk = ~clk;

  // {hcount, vcount, hblank, vblank, hsync, vsync, de, line_start, frame_start}
  function automatic logic [30:0] observed();
    return {hcount, vcount, hblank, vblank, hsync, vsync, de, line_start, frame_start};
  endfunction

  // Expected outputs k en-edges after reset exit (k=0 is the prime edge) with the
  // default test timing; strb=0 masks the strobes for a following en=0 edge.
  function automatic logic [30:0] model(input int k, input bit strb);
    int h, v;
    logic hb, vb, hs, vs, d, ls, fs;
    h  = k % 8;
    v  = (k / 8) % 6;
    hb = (h >= 4);
    vb = (v >= 3);
    hs = (h == 5);
    vs = (v == 4);
    d  = !hb && !vb;
    ls = strb && (h == 0);
    fs = strb && (h == 0) && (v == 0);
    return {W'(h), W'(v), hb, vb, hs, vs, d, ls, fs};
  endfunction

  localparam logic [30:0] ResetVec = {12'd0, 12'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

  task automatic set_defaults();
    h_active  = 12'd4;
    h_sync_s  = 12'd5;
    h_sync_e  = 12'd6;
    h_total   = 12'd8;
    v_active  = 12'd3;
    v_sync_s  = 12'd4;
    v_sync_e  = 12'd5;
    v_total   = 12'd6;
    hsync_pol = 1'b1;
    vsync_pol = 1'b1;
  endtask

  task automatic do_reset();
    en  = 1'b0;
    rst = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  task automatic edge_en(input logic e);
    en = e;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    set_defaults();
    en  = 1'b1;
    rst = 1'b0;
    #1;
    total++;
    if (observed() !== ResetVec) begin
      bad++;
      $display("FAIL reset_async got=%h exp=%h", observed(), ResetVec);
    end
    // Edges while held in reset must not move anything.
    edge_en(1'b1);
    edge_en(1'b1);
    total++;
    if (observed() !== ResetVec) begin
      bad++;
      $display("FAIL reset_held got=%h exp=%h", observed(), ResetVec);
    end
    rst = 1'b1;
    edge_en(1'b0);
    total++;
    if (observed() !== ResetVec) begin
      bad++;
      $display("FAIL reset_unprimed got=%h exp=%h", observed(), ResetVec);
    end
  endtask

  task automatic test_raster();
    int de_cnt = 0;
    int fs_cnt = 0;
    set_defaults();
    do_reset();
    for (int k = 0; k <= 48; k++) begin
      edge_en(1'b1);
      total++;
      if (observed() !== model(k, 1'b1)) begin
        bad++;
        $display("FAIL raster k=%0d got=%h exp=%h", k, observed(), model(k, 1'b1));
      end
      if (k < 48) begin
        de_cnt += int'(de);
        fs_cnt += int'(frame_start);
      end
    end
    total++;
    if (de_cnt != 12) begin
      bad++;
      $display("FAIL raster_de_count got=%0d exp=12", de_cnt);
    end
    total++;
    if (fs_cnt != 1) begin
      bad++;
      $display("FAIL raster_fs_count got=%0d exp=1", fs_cnt);
    end
  endtask

  task automatic test_en_toggle();
    set_defaults();
    do_reset();
    for (int k = 0; k <= 48; k++) begin
      edge_en(1'b1);
      total++;
      if (observed() !== model(k, 1'b1)) begin
        bad++;
        $display("FAIL en_on k=%0d got=%h exp=%h", k, observed(), model(k, 1'b1));
      end
      edge_en(1'b0);
      total++;
      if (observed() !== model(k, 1'b0)) begin
        bad++;
        $display("FAIL en_off k=%0d got=%h exp=%h", k, observed(), model(k, 1'b0));
      end
    end
  endtask

  task automatic test_sync_pol();
    set_defaults();
    h_sync_e  = 12'd5;
    hsync_pol = 1'b0;
    do_reset();
    #1;
    total++;
    if (hsync !== 1'b1) begin
      bad++;
      $display("FAIL sync_pol_reset got=%b exp=1", hsync);
    end
    for (int k = 0; k < 16; k++) begin
      edge_en(1'b1);
      total++;
      if (hsync !== 1'b1) begin
        bad++;
        $display("FAIL sync_empty_low k=%0d got=%b exp=1", k, hsync);
      end
    end
    hsync_pol = 1'b1;
    for (int k = 0; k < 16; k++) begin
      edge_en(1'b1);
      total++;
      if (hsync !== 1'b0) begin
        bad++;
        $display("FAIL sync_empty_high k=%0d got=%b exp=0", k, hsync);
      end
    end
  endtask

  task automatic test_total_change();
    set_defaults();
    do_reset();
    for (int k = 0; k <= 6; k++) edge_en(1'b1);
    total++;
    if ({hcount, vcount} !== {12'd6, 12'd0}) begin
      bad++;
      $display("FAIL shrink_pre got=%0d,%0d exp=6,0", hcount, vcount);
    end
    h_total = 12'd4;
    edge_en(1'b1);
`ifdef VTG_SHADOW_EN
    total++;
    if ({hcount, vcount, line_start} !== {12'd7, 12'd0, 1'b0}) begin
      bad++;
      $display("FAIL shrink_shadow got=%0d,%0d,%b exp=7,0,0", hcount, vcount, line_start);
    end
    edge_en(1'b1);
`endif
    total++;
    if ({hcount, vcount, line_start} !== {12'd0, 12'd1, 1'b1}) begin
      bad++;
      $display("FAIL shrink_wrap got=%0d,%0d,%b exp=0,1,1", hcount, vcount, line_start);
    end
`ifndef VTG_SHADOW_EN
    for (int k = 0; k < 4; k++) edge_en(1'b1);
    total++;
    if ({hcount, vcount, line_start} !== {12'd0, 12'd2, 1'b1}) begin
      bad++;
      $display("FAIL shrink_len4 got=%0d,%0d,%b exp=0,2,1", hcount, vcount, line_start);
    end
`endif
    set_defaults();
  endtask

  task automatic test_reset_mid();
    set_defaults();
    do_reset();
    for (int k = 0; k <= 19; k++) edge_en(1'b1);
    total++;
    if (observed() !== model(19, 1'b1)) begin
      bad++;
      $display("FAIL mid_pre got=%h exp=%h", observed(), model(19, 1'b1));
    end
    #2;
    rst = 1'b0;
    #1;
    total++;
    if (observed() !== ResetVec) begin
      bad++;
      $display("FAIL mid_async got=%h exp=%h", observed(), ResetVec);
    end
    rst = 1'b1;
    edge_en(1'b0);
    total++;
    if (observed() !== ResetVec) begin
      bad++;
      $display("FAIL mid_idle got=%h exp=%h", observed(), ResetVec);
    end
    edge_en(1'b1);
    total++;
    if (observed() !== model(0, 1'b1)) begin
      bad++;
      $display("FAIL mid_reprime got=%h exp=%h", observed(), model(0, 1'b1));
    end
  endtask

  task automatic test_short_total();
    logic [30:0] exp;
    set_defaults();
    h_total = 12'd1;
    do_reset();
    edge_en(1'b1);
    exp = {12'd0, 12'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    total++;
    if (observed() !== exp) begin
      bad++;
      $display("FAIL short_prime got=%h exp=%h", observed(), exp);
    end
    exp = {12'd0, 12'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    for (int k = 0; k < 10; k++) begin
      edge_en(1'b1);
      total++;
      if (observed() !== exp) begin
        bad++;
        $display("FAIL short_run k=%0d got=%h exp=%h", k, observed(), exp);
      end
    end
    set_defaults();
  endtask

  initial begin
    set_defaults();
    test_reset();
    test_raster();
    test_en_toggle();
    test_sync_pol();
    test_total_change();
    test_reset_mid();
    test_short_total();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
